// File: rtl/sram_req_arbiter.sv
// Arbitrates the instruction-fetch and data-access SRAM-like requesters onto one
// downstream port, tracking outstanding owners in order to route responses back.
module sram_req_arbiter #(
  parameter int DEPTH = 4,
  parameter bit RR    = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inst_req,
  input  logic                     inst_wr,
  input  logic [1:0]               inst_size,
  input  logic [31:0]              inst_addr,
  input  logic [31:0]              inst_wdata,
  output logic [31:0]              inst_rdata,
  output logic                     inst_addr_ok,
  output logic                     inst_data_ok,
  input  logic                     data_req,
  input  logic                     data_wr,
  input  logic [1:0]               data_size,
  input  logic [31:0]              data_addr,
  input  logic [31:0]              data_wdata,
  output logic [31:0]              data_rdata,
  output logic                     data_addr_ok,
  output logic                     data_data_ok,
  output logic                     s_req,
  output logic                     s_wr,
  output logic [1:0]               s_size,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [31:0]              s_rdata,
  input  logic                     s_addr_ok,
  input  logic                     s_data_ok,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_spurious
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic             lock;
  logic             locked_owner;
  logic             last_grant;
  logic [DEPTH-1:0] owner_fifo;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      count;

  logic gnt_data;
  logic gnt_req;
  logic full;
  logic empty;
  logic acc;
  logic pop;
  logic head_owner;

  // Owner encoding throughout: 0 = inst, 1 = data.
  always_comb begin
    if (lock)
      gnt_data = locked_owner;
    else if (RR && inst_req && data_req)
      gnt_data = ~last_grant;
    else
      gnt_data = data_req;
  end

  assign gnt_req = gnt_data ? data_req : inst_req;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

  assign s_req   = gnt_req & ~full;
  assign s_wr    = gnt_req & (gnt_data ? data_wr : inst_wr);
  assign s_size  = gnt_req ? (gnt_data ? data_size  : inst_size)  : 2'b0;
  assign s_addr  = gnt_req ? (gnt_data ? data_addr  : inst_addr)  : 32'h0;
  assign s_wdata = gnt_req ? (gnt_data ? data_wdata : inst_wdata) : 32'h0;

  assign acc          = s_req & s_addr_ok;
  assign inst_addr_ok = acc & ~gnt_data;
  assign data_addr_ok = acc & gnt_data;

  // Responses come back strictly in acceptance order, so the FIFO head names the owner.
  assign pop          = s_data_ok & ~empty;
  assign head_owner   = owner_fifo[head];
  assign inst_data_ok = pop & ~head_owner;
  assign data_data_ok = pop & head_owner;
  assign inst_rdata   = inst_data_ok ? s_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? s_rdata : 32'h0;

  assign outstanding  = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock         <= 1'b0;
      locked_owner <= 1'b0;
      last_grant   <= 1'b0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      err_spurious <= 1'b0;
    end else begin
      // A withdrawn request drops s_req, which also releases the lock here.
      lock <= s_req & ~s_addr_ok;
      if (s_req && !s_addr_ok)
        locked_owner <= gnt_data;
      if (acc) begin
        last_grant <= gnt_data;
        tail       <= tail + 1'b1;
      end
      if (pop)
        head <= head + 1'b1;
      case ({acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s_data_ok && empty)
        err_spurious <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (acc)
      owner_fifo[tail] <= gnt_data;
  end

endmodule
